// File: rtl/analog_seq_pkg.sv
// Shared types and default sizes for the analog control-word sequencer.
package analog_seq_pkg;

  localparam int DEF_DEPTH   = 8;
  localparam int DEF_CTRL_W  = 16;
  localparam int DEF_DWELL_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic [DEF_CTRL_W-1:0]  word;
    logic [DEF_DWELL_W-1:0] dwell;
  } seq_entry_t;

endpackage

// File: rtl/analog_seq_table.sv
// Flop-based {word, dwell} table: one synchronous write port, one combinational read port.
module analog_seq_table
  import analog_seq_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int CTRL_W  = DEF_CTRL_W,
  parameter int DWELL_W = DEF_DWELL_W,
  parameter int IDX_W   = $clog2(DEPTH)
) (
  input  logic               clk_in,
  input  logic               reset_int,
  input  logic               we,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [CTRL_W-1:0]  wr_word,
  input  logic [DWELL_W-1:0] wr_dwell,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [CTRL_W-1:0]  rd_word,
  output logic [DWELL_W-1:0] rd_dwell
);

  // Same layout as seq_entry_t, but sized by this instance's parameters.
  typedef struct packed {
    logic [CTRL_W-1:0]  word;
    logic [DWELL_W-1:0] dwell;
  } entry_t;

  entry_t entries [DEPTH];

  always_ff @(posedge clk_in) begin
    if (reset_int) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (we) begin
      entries[wr_addr] <= '{word: wr_word, dwell: wr_dwell};
    end
  end

  // Read sees pre-write contents during a same-cycle write: no write-through.
  assign rd_word  = entries[rd_idx].word;
  assign rd_dwell = entries[rd_idx].dwell;

endmodule

// File: rtl/analog_ctrl_sequencer.sv
// Steps the analog block's control word through a table of {word, dwell} entries.
module analog_ctrl_sequencer
  import analog_seq_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int CTRL_W  = DEF_CTRL_W,
  parameter int DWELL_W = DEF_DWELL_W,
  parameter int IDX_W   = $clog2(DEPTH)
) (
  input  logic               clk_in,
  input  logic               reset_int,
  input  logic               cfg_we,
  input  logic [IDX_W-1:0]   cfg_addr,
  input  logic [CTRL_W-1:0]  cfg_word,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic [IDX_W-1:0]   seq_last,
  input  logic               loop_en,
  input  logic               start,
  input  logic               abort,
  input  logic [CTRL_W-1:0]  idle_word,
  output logic [CTRL_W-1:0]  analog_control,
  output logic               busy,
  output logic               done,
  output logic [IDX_W-1:0]   step_idx
);

  seq_state_t         state, state_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic               done_q, done_d;
  logic               load;
  logic [IDX_W-1:0]   rd_idx;
  logic [CTRL_W-1:0]  rd_word;
  logic [DWELL_W-1:0] rd_dwell;

  analog_seq_table #(
    .DEPTH   (DEPTH),
    .CTRL_W  (CTRL_W),
    .DWELL_W (DWELL_W),
    .IDX_W   (IDX_W)
  ) u_table (
    .clk_in    (clk_in),
    .reset_int (reset_int),
    .we        (cfg_we),
    .wr_addr   (cfg_addr),
    .wr_word   (cfg_word),
    .wr_dwell  (cfg_dwell),
    .rd_idx    (rd_idx),
    .rd_word   (rd_word),
    .rd_dwell  (rd_dwell)
  );

  always_comb begin
    state_d = state;
    ctrl_d  = ctrl_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    done_d  = 1'b0;
    load    = 1'b0;
    rd_idx  = '0;

    unique case (state)
      IDLE: begin
        ctrl_d = idle_word;
        cnt_d  = '0;
        idx_d  = '0;
        if (start && !abort) begin
          state_d = RUN;
          last_d  = seq_last;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          ctrl_d  = idle_word;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (idx_q < last_q) begin
          rd_idx = idx_q + 1'b1;
          load   = 1'b1;
        end else if (loop_en) begin
          load = 1'b1;
        end else begin
          state_d = IDLE;
          ctrl_d  = idle_word;
          cnt_d   = '0;
          idx_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Every entry load (start, advance, wrap) goes through the one read port.
    if (load) begin
      ctrl_d = rd_word;
      cnt_d  = rd_dwell;
      idx_d  = rd_idx;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_int) begin
      state  <= IDLE;
      ctrl_q <= '0;
      cnt_q  <= '0;
      idx_q  <= '0;
      last_q <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_d;
      ctrl_q <= ctrl_d;
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      last_q <= last_d;
      done_q <= done_d;
    end
  end

  assign analog_control = ctrl_q;
  assign busy           = (state == RUN);
  assign done           = done_q;
  assign step_idx       = idx_q;

endmodule

// File: tb/tb_analog_ctrl_sequencer.sv
// Scoreboarded bench: a cycle-queue reference model predicts every output cycle.
module tb_analog_ctrl_sequencer;

  localparam int DEPTH   = 8;
  localparam int CTRL_W  = 16;
  localparam int DWELL_W = 8;
  localparam int IDX_W   = 3;

  logic               clk_in = 1'b0;
  logic               reset_int = 1'b1;
  logic               cfg_we = 1'b0;
  logic [IDX_W-1:0]   cfg_addr = '0;
  logic [CTRL_W-1:0]  cfg_word = '0;
  logic [DWELL_W-1:0] cfg_dwell = '0;
  logic [IDX_W-1:0]   seq_last = '0;
  logic               loop_en = 1'b0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [CTRL_W-1:0]  idle_word = '0;
  logic [CTRL_W-1:0]  analog_control;
  logic               busy;
  logic               done;
  logic [IDX_W-1:0]   step_idx;

  analog_ctrl_sequencer #(
    .DEPTH   (DEPTH),
    .CTRL_W  (CTRL_W),
    .DWELL_W (DWELL_W)
  ) dut (
    .clk_in         (clk_in),
    .reset_int      (reset_int),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_word       (cfg_word),
    .cfg_dwell      (cfg_dwell),
    .seq_last       (seq_last),
    .loop_en        (loop_en),
    .start          (start),
    .abort          (abort),
    .idle_word      (idle_word),
    .analog_control (analog_control),
    .busy           (busy),
    .done           (done),
    .step_idx       (step_idx)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [CTRL_W-1:0] word;
    int unsigned       idx;
  } cyc_t;

  typedef struct {
    logic [CTRL_W-1:0] ctrl;
    logic              busy;
    logic              done;
    logic [IDX_W-1:0]  idx;
  } exp_t;

  // Reference model: the run is a queue of pending output cycles, refilled one entry at a time.
  logic [CTRL_W-1:0]  m_word  [DEPTH];
  logic [DWELL_W-1:0] m_dwell [DEPTH];
  cyc_t               plan [$];
  exp_t               sbq [$];
  bit                 running = 0;
  bit                 finished = 0;
  int unsigned        last_l = 0;
  int unsigned        cur = 0;
  int                 n_vec = 0;
  int                 n_err = 0;

  function automatic void load_entry(int unsigned i);
    cyc_t c;
    plan.delete();
    c.word = m_word[i];
    c.idx  = i;
    for (int k = 0; k <= int'(m_dwell[i]); k++) plan.push_back(c);
    cur = i;
  endfunction

  function automatic exp_t run_exp();
    exp_t e;
    e.ctrl = plan[0].word;
    e.busy = 1'b1;
    e.done = 1'b0;
    e.idx  = IDX_W'(plan[0].idx);
    return e;
  endfunction

  function automatic exp_t idle_exp(logic d);
    exp_t e;
    e.ctrl = idle_word;
    e.busy = 1'b0;
    e.done = d;
    e.idx  = '0;
    return e;
  endfunction

  always @(posedge clk_in) begin
    exp_t e;
    if (reset_int) begin
      running = 0;
      last_l  = 0;
      plan.delete();
      for (int i = 0; i < DEPTH; i++) begin
        m_word[i]  = '0;
        m_dwell[i] = '0;
      end
      e = '{ctrl: '0, busy: 1'b0, done: 1'b0, idx: '0};
    end else begin
      if (!running) begin
        if (start && !abort) begin
          running = 1;
          last_l  = seq_last;
          load_entry(0);
          e = run_exp();
        end else begin
          e = idle_exp(1'b0);
        end
      end else if (abort) begin
        running = 0;
        plan.delete();
        e = idle_exp(1'b0);
      end else begin
        void'(plan.pop_front());
        if (plan.size() > 0) begin
          e = run_exp();
        end else if (cur < last_l) begin
          load_entry(cur + 1);
          e = run_exp();
        end else if (loop_en) begin
          load_entry(0);
          e = run_exp();
        end else begin
          running = 0;
          e = idle_exp(1'b1);
        end
      end
      // Table update lands after this edge's read, matching registered-copy semantics.
      if (cfg_we) begin
        m_word[cfg_addr]  = cfg_word;
        m_dwell[cfg_addr] = cfg_dwell;
      end
    end
    sbq.push_back(e);
  end

  always @(negedge clk_in) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      n_vec++;
      if (analog_control !== e.ctrl || busy !== e.busy || done !== e.done || step_idx !== e.idx) begin
        n_err++;
        $display("FAIL cycle@%0t: got ctrl=%h busy=%b done=%b idx=%0d, expected ctrl=%h busy=%b done=%b idx=%0d",
                 $time, analog_control, busy, done, step_idx, e.ctrl, e.busy, e.done, e.idx);
      end
    end
  end

  initial begin
    repeat (50000) @(posedge clk_in);
    if (!finished) begin
      n_err++;
      $display("FAIL timeout: stimulus did not complete within 50000 cycles");
      $finish;
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic wr(input int a, input logic [CTRL_W-1:0] w, input logic [DWELL_W-1:0] d);
    cfg_we    = 1'b1;
    cfg_addr  = IDX_W'(a);
    cfg_word  = w;
    cfg_dwell = d;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // Reset and idle tracking
    idle_word = 16'hA5A5;
    tick(2);
    if (analog_control !== '0 || busy !== 1'b0 || done !== 1'b0 || step_idx !== '0) begin
      n_err++;
      $display("FAIL reset state: ctrl=%h busy=%b done=%b idx=%0d", analog_control, busy, done, step_idx);
    end
    reset_int = 1'b0;
    tick(5);

    // One-shot run: 3 + 1 + 2 cycles
    wr(0, 16'h0001, 8'd2);
    wr(1, 16'h0002, 8'd0);
    wr(2, 16'h0004, 8'd1);
    seq_last = 3'd2;
    pulse_start();
    tick(9);

    // Looping, then drop loop_en during the third pass
    loop_en = 1'b1;
    pulse_start();
    tick(13);
    loop_en = 1'b0;
    tick(10);

    // Abort in the 2nd cycle of entry 1
    wr(1, 16'h0002, 8'd2);
    pulse_start();
    tick(4);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick(3);

    // start and abort together; abort alone in IDLE
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b0;
    tick(2);

    // start during RUN is ignored
    pulse_start();
    tick(2);
    pulse_start();
    tick(12);

    // Rewrite the active entry mid-loop
    wr(1, 16'h0002, 8'd0);
    loop_en = 1'b1;
    pulse_start();
    tick(3);
    wr(1, 16'hBEEF, 8'd0);
    tick(10);
    loop_en = 1'b0;
    tick(8);

    // Reset mid-run, then a start from the cleared table
    loop_en = 1'b1;
    pulse_start();
    tick(2);
    reset_int = 1'b1;
    tick();
    reset_int = 1'b0;
    loop_en = 1'b0;
    seq_last = 3'd0;
    tick(2);
    pulse_start();
    tick(4);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      cfg_we    = ($urandom_range(0, 7) == 0);
      cfg_addr  = IDX_W'($urandom_range(0, DEPTH - 1));
      cfg_word  = CTRL_W'($urandom);
      cfg_dwell = ($urandom_range(0, 9) == 0) ? DWELL_W'($urandom_range(0, 20)) : DWELL_W'($urandom_range(0, 3));
      seq_last  = IDX_W'($urandom_range(0, DEPTH - 1));
      start     = ($urandom_range(0, 9) == 0);
      abort     = ($urandom_range(0, 59) == 0);
      reset_int = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 39) == 0) loop_en = ~loop_en;
      if ($urandom_range(0, 19) == 0) idle_word = CTRL_W'($urandom);
      tick();
    end
    cfg_we = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    reset_int = 1'b0;
    loop_en = 1'b0;
    tick(3);
    @(negedge clk_in);
    #1;
    finished = 1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    if (n_err == 0) $display("PASS");
    else $display("FAIL");
    $finish;
  end

endmodule
